// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the 64x32 register file and its burst
//   reader. Imported by the interface, the reader top and its slot sub-module.
//   No ports.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int LEN_W  = ADDR_W + 1;   // must hold 64 (full-array burst)
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [LEN_W-1:0]  len_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Address increment; the natural ADDR_W-bit overflow gives the 63 -> 0 wrap.
    function automatic addr_t next_addr(addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/regfile_burst_reader_if.sv
// ----------------------------------------------------------------------------
// regfile_burst_reader_if
//   Bundles every non-clock signal of the burst reader:
//     request   : reqValid, reqReady, reqAddr, reqLen, abort
//     read port : rAddr (to regfile), rDin (combinational read data back)
//     snoop     : wAddr, wDin, wEna (regfile write port, observed only)
//     stream    : outValid, outReady, outData, outLast
//     status    : busy
//   slave  modport : the reader itself
//   master modport : whatever drives requests, owns the regfile and consumes
// ----------------------------------------------------------------------------
interface regfile_burst_reader_if;
    import regfile_pkg::*;

    logic  reqValid;
    logic  reqReady;
    addr_t reqAddr;
    len_t  reqLen;
    logic  abort;
    addr_t rAddr;
    data_t rDin;
    addr_t wAddr;
    data_t wDin;
    logic  wEna;
    logic  outValid;
    logic  outReady;
    data_t outData;
    logic  outLast;
    logic  busy;

    modport slave (
        input  reqValid, reqAddr, reqLen, abort, rDin, wAddr, wDin, wEna, outReady,
        output reqReady, rAddr, outValid, outData, outLast, busy
    );

    modport master (
        output reqValid, reqAddr, reqLen, abort, rDin, wAddr, wDin, wEna, outReady,
        input  reqReady, rAddr, outValid, outData, outLast, busy
    );

endinterface

// File: rtl/regfile_rd_slot.sv
// ----------------------------------------------------------------------------
// regfile_rd_slot
//   Single-entry output register of the burst reader with write forwarding.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clear_i         drop the held beat (abort)
//     capture_i       load a new beat this edge (only raised when slot_free_o)
//     rd_addr_i       address being read
//     rd_data_i       regfile read data for rd_addr_i
//     w_addr_i/w_data_i/w_ena_i   snooped regfile write port
//     last_i          the beat being captured is the final one
//     out_ready_i     consumer ready
//     slot_free_o     register is empty or is being emptied this edge
//     out_valid_o/out_data_o/out_last_o   registered beat
// ----------------------------------------------------------------------------
module regfile_rd_slot
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear_i,
    input  logic  capture_i,
    input  addr_t rd_addr_i,
    input  data_t rd_data_i,
    input  addr_t w_addr_i,
    input  data_t w_data_i,
    input  logic  w_ena_i,
    input  logic  last_i,
    input  logic  out_ready_i,
    output logic  slot_free_o,
    output logic  out_valid_o,
    output data_t out_data_o,
    output logic  out_last_o
);

    logic  valid_q;
    data_t data_q;
    logic  last_q;
    data_t capt_data;

    // A write landing on the capture edge is not yet in rd_data_i, so take it
    // straight from the write port.
    assign capt_data   = (w_ena_i && (w_addr_i == rd_addr_i)) ? w_data_i : rd_data_i;
    assign slot_free_o = !valid_q || out_ready_i;

    // NOTE: the data register is reset as well because outData=0 after reset
    // is visible at the port; it is a single word, not a memory array.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (capture_i) begin
            valid_q <= 1'b1;
            data_q  <= capt_data;
            last_q  <= last_i;
        end else if (out_ready_i) begin
            // Held beat consumed with nothing new behind it.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/regfile_burst_reader.sv
// ----------------------------------------------------------------------------
// regfile_burst_reader
//   Read-side engine for the 64x32 register file. Accepts (start, length)
//   bursts, drives the regfile's asynchronous read address and streams words
//   over valid/ready, forwarding a write that lands on the capture edge.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   regfile_burst_reader_if.slave (request, read, snoop, stream, busy)
// ----------------------------------------------------------------------------
module regfile_burst_reader
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    regfile_burst_reader_if.slave bus
);

    state_e state_q;
    logic   req_ready_q;
    addr_t  cur_addr_q;
    len_t   remain_q;

    logic   slot_free;
    logic   capture;
    logic   out_valid;

    // abort suppresses capture so the slot clears instead of loading.
    assign capture = (state_q == BURST) && slot_free && !bus.abort;

    regfile_rd_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (bus.abort),
        .capture_i   (capture),
        .rd_addr_i   (cur_addr_q),
        .rd_data_i   (bus.rDin),
        .w_addr_i    (bus.wAddr),
        .w_data_i    (bus.wDin),
        .w_ena_i     (bus.wEna),
        .last_i      (remain_q == len_t'(1)),
        .out_ready_i (bus.outReady),
        .slot_free_o (slot_free),
        .out_valid_o (out_valid),
        .out_data_o  (bus.outData),
        .out_last_o  (bus.outLast)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            cur_addr_q  <= '0;
            remain_q    <= '0;
        end else if (bus.abort) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            remain_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A zero-length request is accepted and simply ignored.
                    if (bus.reqValid && req_ready_q && (bus.reqLen != '0)) begin
                        cur_addr_q  <= bus.reqAddr;
                        remain_q    <= bus.reqLen;
                        state_q     <= BURST;
                        req_ready_q <= 1'b0;
                    end
                end
                BURST: begin
                    if (slot_free) begin
                        cur_addr_q <= next_addr(cur_addr_q);
                        remain_q   <= remain_q - len_t'(1);
                        if (remain_q == len_t'(1)) begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rAddr    = cur_addr_q;
    assign bus.reqReady = req_ready_q;
    assign bus.outValid = out_valid;
    assign bus.busy     = (state_q == BURST) || out_valid;

endmodule

// File: tb/tb_regfile_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_regfile_burst_reader
//   Owns a 64x32 regfile model, issues bursts, and compares every consumed beat
//   with the words the burst should return (start+i mod 64).
// ----------------------------------------------------------------------------
module tb_regfile_burst_reader;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_burst_reader_if bus ();

    regfile_burst_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Regfile: combinational read, write on rising edge.
    data_t mem [DEPTH];
    assign bus.rDin = mem[bus.rAddr];
    always @(posedge clk) if (bus.wEna) mem[bus.wAddr] <= bus.wDin;

    int n_vec = 0;
    int n_err = 0;

    data_t  got_data [$];
    logic   got_last [$];
    addr_t  raddr_log [$];
    data_t  exp_data [$];
    int     busy_cycles;
    int     valid_cycles;

    typedef struct {
        addr_t addr;
        len_t  len;
        int    exp_beats;
        addr_t exp_last_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic addr_t wrap(input addr_t a, input int i);
        return addr_t'(int'(a) + i);
    endfunction

    function automatic data_t init_word(input int i);
        if (i == 0 || i == 1) return 32'h2;
        if (i == 2) return 32'h0;
        return 32'hC0DE_0000 | (i * 32'h0101);
    endfunction

    // Expected words for a burst, taken from the regfile before it starts.
    task automatic snapshot(input addr_t addr, input int len);
        exp_data.delete();
        for (int i = 0; i < len; i++) exp_data.push_back(mem[wrap(addr, i)]);
    endtask

    task automatic clear_logs();
        got_data.delete();
        got_last.delete();
        raddr_log.delete();
        busy_cycles  = 0;
        valid_cycles = 0;
    endtask

    task automatic log_raddr();
        if (!bus.reqReady && (raddr_log.size() == 0 || raddr_log[$] != bus.rAddr))
            raddr_log.push_back(bus.rAddr);
    endtask

    task automatic send_req(input addr_t addr, input int len);
        int cyc = 0;
        while (!bus.reqReady && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check1("req_ready_wait", bus.reqReady, 1'b1);
        bus.reqValid = 1'b1;
        bus.reqAddr  = addr;
        bus.reqLen   = len_t'(len);
        @(negedge clk);
        bus.reqValid = 1'b0;
    endtask

    task automatic run_burst(input addr_t addr, input int len, input bit rand_ready, input bit rand_wr);
        int    cyc = 0;
        int    budget = 64 * 8 + 20;
        addr_t wa;
        clear_logs();
        send_req(addr, len);
        if (len == 0) begin
            repeat (4) begin
                log_raddr();
                if (bus.busy) busy_cycles++;
                if (bus.outValid) valid_cycles++;
                @(negedge clk);
            end
        end else begin
            while (got_data.size() < len && cyc < budget) begin
                bus.outReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.wEna = 1'b0;
                if (rand_wr && len < 64 && $urandom_range(0, 2) == 0) begin
                    wa = addr_t'($urandom_range(0, DEPTH - 1));
                    // Only touch words outside the burst so the expectation stays fixed.
                    if (((int'(wa) - int'(addr) + DEPTH) % DEPTH) >= len) begin
                        bus.wEna  = 1'b1;
                        bus.wAddr = wa;
                        bus.wDin  = $urandom;
                    end
                end
                log_raddr();
                if (bus.outValid && bus.outReady) begin
                    got_data.push_back(bus.outData);
                    got_last.push_back(bus.outLast);
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.wEna     = 1'b0;
        bus.outReady = 1'b1;
        check1("burst_within_budget", cyc < budget, 1'b1);
    endtask

    task automatic compare_burst(input string tag, input addr_t addr, input int len);
        check({tag, "_beats"}, got_data.size(), len);
        for (int i = 0; i < got_data.size() && i < len; i++) begin
            check({tag, "_data"}, got_data[i], exp_data[i]);
            check1({tag, "_last"}, got_last[i], i == len - 1);
        end
        check({tag, "_raddr_n"}, raddr_log.size(), len);
        for (int i = 0; i < raddr_log.size() && i < len; i++)
            check({tag, "_raddr"}, raddr_log[i], wrap(addr, i));
        check1({tag, "_busy_after"}, bus.busy, 1'b0);
        check1({tag, "_valid_after"}, bus.outValid, 1'b0);
        if (len == 0) begin
            check({tag, "_busy_cycles"}, busy_cycles, 0);
            check({tag, "_valid_cycles"}, valid_cycles, 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_reqReady"}, bus.reqReady, 1'b1);
        check1({tag, "_outValid"}, bus.outValid, 1'b0);
        check ({tag, "_outData"},  bus.outData,  32'h0);
        check1({tag, "_outLast"},  bus.outLast,  1'b0);
        check ({tag, "_rAddr"},    bus.rAddr,    32'h0);
        check1({tag, "_busy"},     bus.busy,     1'b0);
    endtask

    initial begin
        int    cyc;
        int    stall_idx;
        bit    done_w;
        bit    aborted;
        data_t held_d;
        logic  held_l;
        addr_t held_a;
        addr_t ra;
        int    rl;

        vecs[0] = '{addr: 6'd0,  len: 7'd3,  exp_beats: 3,  exp_last_addr: 6'd2};
        vecs[1] = '{addr: 6'd62, len: 7'd4,  exp_beats: 4,  exp_last_addr: 6'd1};
        vecs[2] = '{addr: 6'd5,  len: 7'd0,  exp_beats: 0,  exp_last_addr: 6'd0};
        vecs[3] = '{addr: 6'd17, len: 7'd64, exp_beats: 64, exp_last_addr: 6'd16};
        vecs[4] = '{addr: 6'd63, len: 7'd1,  exp_beats: 1,  exp_last_addr: 6'd63};
        vecs[5] = '{addr: 6'd40, len: 7'd2,  exp_beats: 2,  exp_last_addr: 6'd41};

        rst          = 1'b1;
        bus.reqValid = 1'b0;
        bus.reqAddr  = '0;
        bus.reqLen   = '0;
        bus.abort    = 1'b0;
        bus.wAddr    = '0;
        bus.wDin     = '0;
        bus.wEna     = 1'b0;
        bus.outReady = 1'b1;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Load the regfile through its write port.
        for (int i = 0; i < DEPTH; i++) begin
            bus.wEna  = 1'b1;
            bus.wAddr = addr_t'(i);
            bus.wDin  = init_word(i);
            @(negedge clk);
        end
        bus.wEna = 1'b0;
        @(negedge clk);

        // Table: full-speed bursts.
        for (int v = 0; v < 6; v++) begin
            snapshot(vecs[v].addr, int'(vecs[v].len));
            run_burst(vecs[v].addr, int'(vecs[v].len), 1'b0, 1'b0);
            compare_burst($sformatf("vec%0d", v), vecs[v].addr, int'(vecs[v].len));
            check($sformatf("vec%0d_count", v), got_data.size(), vecs[v].exp_beats);
            if (vecs[v].exp_beats > 0 && got_data.size() > 0) begin
                check($sformatf("vec%0d_last_word", v), got_data[$], mem[vecs[v].exp_last_addr]);
                if (raddr_log.size() > 0)
                    check($sformatf("vec%0d_last_raddr", v), raddr_log[$], vecs[v].exp_last_addr);
            end
        end

        // Three-cycle stall on beat 3 of a len-5 burst; a write to the word
        // about to be read lands during the stall and must show up on beat 4.
        snapshot(6'd20, 5);
        exp_data[3] = 32'h5555_AAAA;
        clear_logs();
        send_req(6'd20, 5);
        cyc = 0;
        stall_idx = -1;
        held_d = '0;
        held_l = 1'b0;
        held_a = '0;
        while (got_data.size() < 5 && cyc < 100) begin
            bus.wEna = 1'b0;
            if (stall_idx < 0 && got_data.size() == 2 && bus.outValid) begin
                stall_idx = 0;
                held_d = bus.outData;
                held_l = bus.outLast;
                held_a = bus.rAddr;
                bus.wEna  = 1'b1;
                bus.wAddr = 6'd23;
                bus.wDin  = 32'h5555_AAAA;
            end else if (stall_idx >= 1 && stall_idx <= 3) begin
                check("stall_data_hold", bus.outData, held_d);
                check1("stall_last_hold", bus.outLast, held_l);
                check("stall_raddr_hold", bus.rAddr, held_a);
                check1("stall_valid_hold", bus.outValid, 1'b1);
            end
            bus.outReady = (stall_idx >= 0 && stall_idx <= 2) ? 1'b0 : 1'b1;
            log_raddr();
            if (bus.outValid && bus.outReady) begin
                got_data.push_back(bus.outData);
                got_last.push_back(bus.outLast);
            end
            if (stall_idx >= 0) stall_idx++;
            @(negedge clk);
            cyc++;
        end
        bus.wEna = 1'b0;
        bus.outReady = 1'b1;
        check1("stall_seen", stall_idx > 3, 1'b1);
        compare_burst("stall", 6'd20, 5);

        // Write to address 5 landing on the edge that captures address 5.
        snapshot(6'd3, 4);
        exp_data[2] = 32'hDEAD_BEEF;
        check1("fwd_old_differs", mem[5] != 32'hDEAD_BEEF, 1'b1);
        clear_logs();
        send_req(6'd3, 4);
        cyc = 0;
        done_w = 1'b0;
        while (got_data.size() < 4 && cyc < 100) begin
            bus.wEna = 1'b0;
            if (!done_w && !bus.reqReady && bus.rAddr == 6'd5) begin
                bus.wEna  = 1'b1;
                bus.wAddr = 6'd5;
                bus.wDin  = 32'hDEAD_BEEF;
                done_w    = 1'b1;
            end
            log_raddr();
            if (bus.outValid && bus.outReady) begin
                got_data.push_back(bus.outData);
                got_last.push_back(bus.outLast);
            end
            @(negedge clk);
            cyc++;
        end
        bus.wEna = 1'b0;
        compare_burst("fwd", 6'd3, 4);

        // Abort while beat 2 of a len-8 burst is on the bus.
        clear_logs();
        snapshot(6'd30, 1);
        send_req(6'd30, 8);
        cyc = 0;
        aborted = 1'b0;
        while (!aborted && cyc < 50) begin
            if (got_data.size() == 1 && bus.outValid) begin
                bus.outReady = 1'b0;
                bus.abort    = 1'b1;
                aborted      = 1'b1;
            end else begin
                bus.outReady = 1'b1;
                if (bus.outValid) begin
                    got_data.push_back(bus.outData);
                    got_last.push_back(bus.outLast);
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.abort    = 1'b0;
        bus.outReady = 1'b1;
        check1("abort_reached", aborted, 1'b1);
        if (got_data.size() > 0) check("abort_beat0", got_data[0], exp_data[0]);
        check1("abort_outValid", bus.outValid, 1'b0);
        check1("abort_outLast", bus.outLast, 1'b0);
        check1("abort_reqReady", bus.reqReady, 1'b1);
        check1("abort_busy", bus.busy, 1'b0);

        // abort beats a request presented in the same cycle.
        bus.reqValid = 1'b1;
        bus.reqAddr  = 6'd40;
        bus.reqLen   = 7'd2;
        bus.abort    = 1'b1;
        @(negedge clk);
        bus.reqValid = 1'b0;
        bus.abort    = 1'b0;
        valid_cycles = 0;
        busy_cycles  = 0;
        repeat (3) begin
            if (bus.outValid) valid_cycles++;
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
        check("abort_vs_req_valid", valid_cycles, 0);
        check("abort_vs_req_busy", busy_cycles, 0);

        snapshot(6'd10, 1);
        run_burst(6'd10, 1, 1'b0, 1'b0);
        compare_burst("post_abort", 6'd10, 1);

        // Reset in the middle of a burst.
        send_req(6'd50, 10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid_rst");
        snapshot(6'd7, 3);
        run_burst(6'd7, 3, 1'b0, 1'b0);
        compare_burst("post_rst", 6'd7, 3);

        // Random bursts with random backpressure and unrelated writes.
        for (int n = 0; n < 25; n++) begin
            ra = addr_t'($urandom_range(0, DEPTH - 1));
            rl = (n % 8 == 7) ? 0 : int'($urandom_range(1, 64));
            snapshot(ra, rl);
            run_burst(ra, rl, 1'b1, 1'b1);
            compare_burst($sformatf("rnd%0d", n), ra, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
